// File: rtl/fifo_rd_streamer.sv
// fifo_rd_streamer
// Read-side drain controller for the async FIFO, running in the read clock
// domain. It pops words from the FIFO read port and presents them as a
// valid/ready stream. A 2-entry output buffer absorbs the FIFO's one-cycle
// read latency, so back-pressure never loses or duplicates a word. A flush
// mode discards buffered and FIFO data. A wrapping counter tracks the number
// of delivered words.
//
// Ports
//   rclk       read-domain clock, rising edge
//   rrst_n     asynchronous active-low reset
//   empty      FIFO empty flag (rclk domain)
//   fifo_data  FIFO data_out, valid the cycle after r_en was sampled high
//   r_en       FIFO read enable (combinational)
//   m_data     stream data (head of output buffer)
//   m_valid    stream valid
//   m_ready    downstream ready
//   flush      request to discard buffered and FIFO data (level)
//   flush_busy high while flushing
//   rd_count   delivered-word count, wraps modulo 2^CNT_W
module fifo_rd_streamer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             r_en,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  input  logic             flush,
  output logic             flush_busy,
  output logic [CNT_W-1:0] rd_count
);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t           state_r;
  logic [1:0]       count_r;      // words held in the output buffer (0..2)
  logic             inflight_r;   // a FIFO read issued last cycle lands now
  logic [WIDTH-1:0] buf0_r;       // head entry
  logic [WIDTH-1:0] buf1_r;       // second entry
  logic             flush_busy_r;
  logic [CNT_W-1:0] rd_count_r;

  logic             pop_s;
  logic [1:0]       occ_s;

  assign m_valid    = (count_r != 2'd0);
  assign m_data     = buf0_r;
  assign flush_busy = flush_busy_r;
  assign rd_count   = rd_count_r;
  assign pop_s      = m_valid && m_ready;

  // Read enable: in RUN only request when the buffer still has room for the
  // word after accounting for the in-flight read and this cycle's pop, so
  // count+inflight can never exceed 2. In FLUSH just drain whatever is there.
  always_comb begin
    occ_s = count_r + {1'b0, inflight_r} - {1'b0, pop_s};
    r_en  = 1'b0;
    if (!rrst_n) begin
      r_en = 1'b0;
    end else if (empty) begin
      r_en = 1'b0;
    end else if (state_r == ST_FLUSH) begin
      r_en = 1'b1;
    end else if (occ_s < 2'd2) begin
      r_en = 1'b1;
    end else begin
      r_en = 1'b0;
    end
  end

  // Control FSM, output buffer and delivered-word counter.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_r      <= ST_RUN;
      count_r      <= 2'd0;
      inflight_r   <= 1'b0;
      buf0_r       <= '0;
      buf1_r       <= '0;
      flush_busy_r <= 1'b0;
      rd_count_r   <= '0;
    end else begin
      inflight_r <= r_en;
      case (state_r)
        ST_RUN: begin
          if (pop_s) begin
            rd_count_r <= rd_count_r + CNT_W'(1);
          end
          if (flush) begin
            // A pop in the flush cycle still completes; everything else,
            // including a word in flight, is dropped.
            state_r      <= ST_FLUSH;
            count_r      <= 2'd0;
            flush_busy_r <= 1'b1;
          end else begin
            case ({inflight_r, pop_s})
              2'b10: begin
                if (count_r == 2'd0) begin
                  buf0_r <= fifo_data;
                end else begin
                  buf1_r <= fifo_data;
                end
                count_r <= count_r + 2'd1;
              end
              2'b01: begin
                buf0_r  <= buf1_r;
                count_r <= count_r - 2'd1;
              end
              2'b11: begin
                // Capture and pop together: occupancy unchanged, head advances.
                if (count_r == 2'd1) begin
                  buf0_r <= fifo_data;
                end else begin
                  buf0_r <= buf1_r;
                  buf1_r <= fifo_data;
                end
              end
              default: begin
                count_r <= count_r;
              end
            endcase
          end
        end
        ST_FLUSH: begin
          // Captured data is ignored; leave once nothing is left to read.
          if (empty && !inflight_r) begin
            state_r      <= ST_RUN;
            flush_busy_r <= 1'b0;
          end
        end
        default: begin
          state_r      <= ST_RUN;
          count_r      <= 2'd0;
          flush_busy_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Testbench for fifo_rd_streamer: directed scenarios followed by randomized
// traffic, all checked against a transaction-level model (FIFO queue, expected
// word queue, delivered count, flush-busy tracking).
module tb_fifo_rd_streamer;

  localparam int WIDTH = 8;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rrst_n;
  logic             empty;
  logic [WIDTH-1:0] fifo_data;
  logic             r_en;
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_ready;
  logic             flush;
  logic             flush_busy;
  logic [CNT_W-1:0] rd_count;

  logic             r_en4;
  logic [WIDTH-1:0] m_data4;
  logic             m_valid4;
  logic             flush_busy4;
  logic [3:0]       rd_count4;

  fifo_rd_streamer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_dut (
    .rclk(clk), .rrst_n(rrst_n), .empty(empty), .fifo_data(fifo_data),
    .r_en(r_en), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .flush(flush), .flush_busy(flush_busy), .rd_count(rd_count)
  );

  // Narrow-counter twin sharing all inputs, used for the wrap behaviour.
  fifo_rd_streamer #(.WIDTH(WIDTH), .CNT_W(4)) u_dut_w4 (
    .rclk(clk), .rrst_n(rrst_n), .empty(empty), .fifo_data(fifo_data),
    .r_en(r_en4), .m_data(m_data4), .m_valid(m_valid4), .m_ready(m_ready),
    .flush(flush), .flush_busy(flush_busy4), .rd_count(rd_count4)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Model state
  logic [WIDTH-1:0] fifo_q[$];
  logic [WIDTH-1:0] exp_q[$];
  int               model_cnt;
  bit               model_busy;
  int               cyc;
  int               ren_cyc[$];
  int               pop_cyc[$];
  logic [WIDTH-1:0] last_pop;
  bit               have_prev;
  bit               prev_hold;
  bit               prev_flush_s;
  bit               prev_ren;
  logic [WIDTH-1:0] prev_data;

  task automatic push(input logic [WIDTH-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
    empty = 1'b0;
  endtask

  // One clock cycle: check at the falling edge, then model the FIFO response
  // just after the rising edge.
  task automatic step();
    bit               ren_s;
    bit               pop_s;
    bit               flush_s;
    bit               inflight_m;
    logic [WIDTH-1:0] exp_w;
    @(negedge clk);
    inflight_m = have_prev && prev_ren;
    if (empty) check_value("r_en_while_empty", 32'(r_en), 32'd0);
    check_value("rd_count", 32'(rd_count), 32'(model_cnt[15:0]));
    check_value("rd_count_w4", 32'(rd_count4), 32'(model_cnt[3:0]));
    check_value("twin_r_en", 32'(r_en4), 32'(r_en));
    check_value("flush_busy", 32'(flush_busy), 32'(model_busy));
    if (have_prev && prev_hold && !prev_flush_s) begin
      check_value("hold_valid", 32'(m_valid), 32'd1);
      check_value("hold_data", 32'(m_data), 32'(prev_data));
    end
    if (model_busy) begin
      check_value("flush_valid", 32'(m_valid), 32'd0);
      check_value("flush_r_en", 32'(r_en), 32'(!empty));
    end
    if (m_valid && exp_q.size() == 0) check_value("spurious_valid", 32'(m_valid), 32'd0);
    pop_s = m_valid && m_ready;
    if (pop_s) begin
      model_cnt++;
      pop_cyc.push_back(cyc);
      if (exp_q.size() > 0) begin
        exp_w = exp_q.pop_front();
        check_value("m_data", 32'(m_data), 32'(exp_w));
        last_pop = exp_w;
      end
    end
    ren_s = r_en;
    if (ren_s) ren_cyc.push_back(cyc);
    flush_s = flush && !model_busy;
    prev_hold    = m_valid && !m_ready;
    prev_data    = m_data;
    prev_flush_s = flush_s;
    prev_ren     = ren_s;
    have_prev    = 1'b1;
    if (flush_s) model_busy = 1'b1;
    else if (model_busy && empty && !inflight_m) model_busy = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    if (ren_s) begin
      if (fifo_q.size() > 0) fifo_data = fifo_q.pop_front();
      else check_value("fifo_underflow", 32'd1, 32'd0);
    end
    if (flush_s) exp_q.delete();
    empty = (fifo_q.size() == 0);
  endtask

  task automatic drain(input int budget);
    m_ready = 1'b1;
    for (int i = 0; i < budget && (exp_q.size() > 0 || !empty); i++) step();
    check_value("drain_done", 32'(exp_q.size()), 32'd0);
    repeat (3) step();
  endtask

  task automatic do_reset();
    rrst_n = 1'b0;
    flush = 1'b0;
    m_ready = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    empty = 1'b1;
    model_cnt = 0;
    model_busy = 1'b0;
    have_prev = 1'b0;
    #1;
    check_value("rst_r_en", 32'(r_en), 32'd0);
    check_value("rst_m_valid", 32'(m_valid), 32'd0);
    check_value("rst_m_data", 32'(m_data), 32'd0);
    check_value("rst_flush_busy", 32'(flush_busy), 32'd0);
    check_value("rst_rd_count", 32'(rd_count), 32'd0);
    check_value("rst_rd_count_w4", 32'(rd_count4), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rrst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int               c0;
    logic [WIDTH-1:0] first_w;
    rrst_n = 1'b1; empty = 1'b1; fifo_data = '0; m_ready = 1'b0; flush = 1'b0;
    cyc = 0; model_cnt = 0; model_busy = 1'b0; have_prev = 1'b0; last_pop = '0;
    #2;
    do_reset();

    // 1: three words, downstream always ready -> back-to-back timing
    m_ready = 1'b1;
    ren_cyc.delete(); pop_cyc.delete();
    c0 = cyc;
    push(8'h11); push(8'h22); push(8'h33);
    repeat (8) step();
    check_value("t1_ren_pulses", 32'(ren_cyc.size()), 32'd3);
    check_value("t1_pops", 32'(pop_cyc.size()), 32'd3);
    if (ren_cyc.size() == 3 && pop_cyc.size() == 3) begin
      check_value("t1_ren0", 32'(ren_cyc[0]), 32'(c0));
      check_value("t1_ren2", 32'(ren_cyc[2]), 32'(c0 + 2));
      check_value("t1_pop0", 32'(pop_cyc[0]), 32'(c0 + 2));
      check_value("t1_pop2", 32'(pop_cyc[2]), 32'(c0 + 4));
    end
    check_value("t1_rd_count", 32'(rd_count), 32'd3);
    check_value("t1_valid_low", 32'(m_valid), 32'd0);

    // 2: five words with back-pressure -> only two reads, head held
    m_ready = 1'b0;
    ren_cyc.delete();
    first_w = 8'($urandom);
    push(first_w);
    for (int i = 0; i < 4; i++) push(8'($urandom));
    repeat (10) step();
    check_value("t2_ren_pulses", 32'(ren_cyc.size()), 32'd2);
    check_value("t2_valid", 32'(m_valid), 32'd1);
    check_value("t2_head", 32'(m_data), 32'(first_w));
    drain(40);
    check_value("t2_rd_count", 32'(rd_count), 32'd8);

    // 3: alternating ready with A0..A7
    for (int i = 0; i < 8; i++) push(8'hA0 + 8'(i));
    for (int i = 0; i < 60 && exp_q.size() > 0; i++) begin
      m_ready = (i % 2 == 0);
      step();
    end
    check_value("t3_all_delivered", 32'(exp_q.size()), 32'd0);
    check_value("t3_last", 32'(last_pop), 32'hA7);
    drain(10);
    check_value("t3_rd_count", 32'(rd_count), 32'd16);

    // 4: flush with 2 buffered words and 4 still in the FIFO
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(8'($urandom));
    repeat (6) step();
    check_value("t4_buffer_full", 32'(m_valid), 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_value("t4_valid_off", 32'(m_valid), 32'd0);
    check_value("t4_busy_on", 32'(flush_busy), 32'd1);
    ren_cyc.delete();
    for (int i = 0; i < 20 && flush_busy; i++) step();
    check_value("t4_busy_off", 32'(flush_busy), 32'd0);
    check_value("t4_flush_reads", 32'(ren_cyc.size()), 32'd4);
    check_value("t4_rd_count", 32'(rd_count), 32'd16);
    push(8'h5A);
    drain(20);
    check_value("t4_new_word", 32'(last_pop), 32'h5A);
    check_value("t4_rd_count_after", 32'(rd_count), 32'd17);

    // 5: reset with a word buffered and one in flight
    m_ready = 1'b0;
    push(8'h01); push(8'h02); push(8'h03);
    step(); step();
    check_value("t5_valid_before", 32'(m_valid), 32'd1);
    do_reset();
    repeat (5) step();
    check_value("t5_valid_after", 32'(m_valid), 32'd0);
    check_value("t5_r_en_after", 32'(r_en), 32'd0);

    // 6: 17 words -> 4-bit counter wraps to 1
    for (int i = 0; i < 17; i++) push(8'($urandom));
    drain(60);
    check_value("t6_wrap_w4", 32'(rd_count4), 32'd1);
    check_value("t6_rd_count", 32'(rd_count), 32'd17);

    // 7: randomized traffic with back-pressure and occasional flushes
    for (int i = 0; i < 1500; i++) begin
      flush   = ($urandom_range(0, 39) == 0);
      m_ready = ($urandom_range(0, 3) != 0);
      if (!flush && !model_busy && fifo_q.size() < 6 && $urandom_range(0, 1) == 1)
        push(8'($urandom));
      step();
    end
    flush = 1'b0;
    for (int i = 0; i < 20 && model_busy; i++) step();
    drain(100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_rd_streamer.md
Name: fifo_rd_streamer

Overview:
- Read-side drain controller for the async FIFO, in the read clock domain.
- Pops words from the FIFO read port (r_en / data_out / empty) and presents them as a valid/ready stream to downstream logic.
- A 2-entry output buffer absorbs the FIFO's 1-cycle read latency, so back-pressure never loses or duplicates a word.
- Provides a flush mode that discards the FIFO contents, plus a count of delivered words.

Parameters:
- WIDTH, 8, data word width; matches the FIFO data width.
- CNT_W, 16, width of the delivered-word counter.

Ports:
- rclk  input  1  read-domain clock; all logic on rising edge.
- rrst_n  input  1  asynchronous, active-low reset.
- empty  input  1  FIFO empty flag, synchronous to rclk.
- fifo_data  input  WIDTH  FIFO data_out; valid in the cycle after r_en was sampled high.
- r_en  output  1  FIFO read enable; combinational.
- m_data  output  WIDTH  stream data (head of output buffer).
- m_valid  output  1  stream valid.
- m_ready  input  1  downstream ready.
- flush  input  1  request to discard buffered and FIFO data; sampled level.
- flush_busy  output  1  high while in FLUSH state.
- rd_count  output  CNT_W  words delivered on the stream; wraps modulo 2^CNT_W.

Behaviour:
- Reset (rrst_n=0, asynchronous) forces:
  - state=RUN, buffer count=0, inflight=0;
  - m_valid=0, m_data=0, flush_busy=0, rd_count=0;
  - r_en=0 while reset is asserted.
- Reset mid-transfer drops buffered words and any in-flight word; the FIFO's own reset is handled separately.
- pop = m_valid && m_ready; a word transfers on the rclk edge where pop=1.
- inflight register = r_en of the previous cycle.
- FIFO read timing:
  - r_en high in cycle N → fifo_data captured into the buffer at the end of cycle N+1.
  - The word is visible on m_data/m_valid in cycle N+2.
- Buffer:
  - 2-entry, in-order; m_valid = (count>0); m_data = head entry.
  - While m_valid=1 and m_ready=0, m_data is held stable.
- RUN state:
  - r_en = !empty && (count + inflight − pop) < 2.
  - count+inflight never exceeds 2, so overflow is impossible.
  - With m_ready held 1 and the FIFO non-empty, sustained throughput is 1 word/cycle.
- Simultaneous capture and pop in one cycle: count unchanged, head advances.
- empty rising while a read is in flight: the in-flight word is still captured; no new r_en.
- rd_count increments by 1 on every pop, in RUN only.
- Entering FLUSH from RUN:
  - Triggered when flush=1 is sampled.
  - If pop is also high that cycle, the pop completes and rd_count increments.
  - At that edge: count:=0, m_valid:=0, flush_busy:=1.
- FLUSH state:
  - r_en = !empty; captured fifo_data is discarded (never written to the buffer).
  - m_valid stays 0; flush input is ignored.
  - A word in flight at FLUSH entry is discarded.
- Exiting FLUSH: in the first cycle with empty=1 and inflight=0, go to RUN at the next edge; flush_busy:=0.
  - If flush is still high on that return edge, it re-enters FLUSH on the following cycle.
- m_ready has no effect in FLUSH.
- r_en is never asserted while empty=1, in any state.

Test Plan:
- Reset, then FIFO holds 0x11,0x22,0x33 with m_ready=1 → r_en high 3 consecutive cycles; m_data=0x11,0x22,0x33 on consecutive cycles starting 2 cycles after the first r_en; rd_count=3; m_valid falls after the last word.
- FIFO holds 5 words, m_ready=0 → exactly 2 r_en pulses, m_valid=1, m_data=first word held stable. Then m_ready=1 → all 5 words delivered in order, none lost or duplicated; count never exceeds 2.
- m_ready toggling 1,0,1,0 with 8 words (0xA0..0xA7) → delivered sequence A0..A7 in order; rd_count=8.
- Buffer holding 2 words plus 4 words in the FIFO, assert flush 1 cycle → m_valid=0 next cycle; flush_busy high until FIFO empty (4 r_en pulses); then RUN; rd_count unchanged; a new word 0x5A written afterwards is delivered as 0x5A.
- Assert rrst_n=0 while m_valid=1 with 1 word in flight → all outputs 0 immediately; after release with FIFO empty, r_en stays 0 and m_valid stays 0.
- CNT_W=4 with 17 words streamed → rd_count wraps to 1.
